// File: rtl/aes_key_expand.sv
// aes_key_expand
// Iterative AES-128 key schedule. A 128-bit cipher key is accepted through a
// valid/ready handshake. The 11 round keys are then produced one per clock into
// an internal register file. Any round key can be read through a registered
// port indexed by round number.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-low; clears state, register file and read port
//   key_in     : cipher key, bit 0 = MSB of byte 0
//   key_valid  : key_in is valid
//   key_ready  : key can be accepted (IDLE or DONE)
//   round_sel  : round-key index 0..10; 11..15 read as zero
//   round_key  : registered read data, one cycle after round_sel
//   busy       : expansion in progress
//   keys_done  : all 11 round keys of the last accepted key are valid
module aes_key_expand (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [3:0]   round_sel,
  output logic [0:127] round_key,
  output logic         busy,
  output logic         keys_done
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state, state_nxt;
  logic [0:127] rk [0:10];
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         accept;
  logic [0:127] prev_key, next_key;
  logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;

  // GF(2^8) multiply by x: walks rcon through 01,02,...,80,1B,36.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  assign key_ready = (state == IDLE) || (state == DONE);
  assign busy      = (state == EXPAND);
  assign accept    = key_valid && key_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (rnd == 4'd10) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  // One round of the schedule: rk[rnd] derived from rk[rnd-1]. The word
  // slices keep FIPS byte order (w0 is the leftmost 32 bits of the key).
  always_comb begin
    prev_key = rk[rnd - 4'd1];
    w0 = prev_key[0:31];
    w1 = prev_key[32:63];
    w2 = prev_key[64:95];
    w3 = prev_key[96:127];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
      rnd       <= 4'd0;
      rcon      <= 8'h01;
      keys_done <= 1'b0;
      round_key <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rk[0]     <= key_in;
        rnd       <= 4'd1;
        rcon      <= 8'h01;
        keys_done <= 1'b0;
      end else if (state == EXPAND) begin
        rk[rnd] <= next_key;
        rnd     <= rnd + 4'd1;
        rcon    <= xtime(rcon);
        if (rnd == 4'd10) keys_done <= 1'b1;
      end
      round_key <= (round_sel <= 4'd10) ? rk[round_sel] : '0;
    end
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule that sits directly upstream of the `Encrypt` core. It accepts a 128-bit cipher key through a valid/ready handshake and generates the 11 round keys, one per clock. It stores them in an internal register file and serves any round key through a registered read port indexed by round number. The `Encrypt` core reads keys from this block instead of expanding the key itself.

## Interface
- No parameters. The block is fixed to AES-128: Nk=4, Nr=10, 11 round keys.
- `clk  in  1`: single clock. All state changes on the rising edge.
- `reset  in  1`: synchronous, active-low. Sampled on the rising edge of `clk`.
- `key_in  in  [0:127]`: cipher key. Bit 0 is the MSB of byte 0 (FIPS-197 byte order).
- `key_valid  in  1`: `key_in` is valid.
- `key_ready  out  1`: the block accepts a key. Combinational from state; high in IDLE and DONE.
- `round_sel  in  [3:0]`: round-key index, 0..10.
- `round_key  out  [0:127]`: registered read data for `round_sel`.
- `busy  out  1`: expansion in progress (state EXPAND).
- `keys_done  out  1`: all 11 round keys for the last accepted key are valid.

## Operation
- **Storage:** `rk[0..10]`, each 128 bits. `w0..w3` map to `rk[i][0:31]`..`rk[i][96:127]`.
- **FSM states:** IDLE, EXPAND, DONE.
  - IDLE → EXPAND when `key_valid && key_ready`.
  - DONE → EXPAND when `key_valid && key_ready`.
  - EXPAND → DONE after `rk[10]` is written.
- **On accept:**
  - `rk[0] <= key_in`.
  - Round counter `rnd <= 1`.
  - `rcon <= 8'h01`.
  - `keys_done <= 0`.
- **Each EXPAND cycle:** compute `rk[rnd]` from `rk[rnd-1]`.
  - `t = SubWord(RotWord(w3)) ^ {rcon,24'h0}`.
  - `w0' = w0^t`, `w1' = w1^w0'`, `w2' = w2^w1'`, `w3' = w3^w2'`.
  - Then `rnd <= rnd+1` and `rcon <= xtime(rcon)`. xtime is a shift left, XOR 8'h1B on carry-out. Sequence: 01,02,04,08,10,20,40,80,1B,36.
- **SubWord:** four parallel lookups in a local FIPS-197 S-box table. Purely combinational; no extra cycle.
- **Completion:** when `rnd==10` is written, the FSM enters DONE and `keys_done <= 1`.
- **Key offered during EXPAND:** `key_valid` is ignored (`key_ready=0`) and the key is not captured. The source must hold it.
- **Read port:** `round_key <= (round_sel<=10) ? rk[round_sel] : 128'h0` every cycle, in every state.
  - Reads of rounds not yet rewritten during EXPAND return stale data.
  - Consumers must wait for `keys_done`.
- **Reset (`reset==0` at a rising edge):** takes priority over everything, including mid-expansion.
  - State → IDLE.
  - All `rk[*]` → 0.
  - `round_key` → 0, `keys_done` → 0, `busy` → 0, `rnd` → 0, `rcon` → 8'h01.
  - `key_ready` is 1 from the first cycle after reset.
  - A key offered in the same cycle as reset is dropped.

## Timing
- **Accept edge E0:** the edge where `key_valid && key_ready` is sampled. `rk[0]` is written at E0.
- **Round-key writes:** `rk[1]`..`rk[10]` are written at E1..E10.
- **Flags:**
  - `busy` is high from after E0 through E10, exactly 10 cycles.
  - `keys_done` is high from after E10.
  - Total latency from accept to `keys_done`: 10 cycles.
- **Read latency:** 1 cycle. `round_sel` sampled at edge N appears on `round_key` after edge N.
- **Back-to-back keys:** a key may be accepted in the first DONE cycle. `keys_done` drops after that edge, and `rk[*]` is overwritten progressively.
- **Throughput:** one key per 11 cycles maximum.
- **Round-key hold:** `keys_done` and `rk[*]` stay stable in DONE indefinitely until a new key or reset.

## Test plan
- **FIPS-197 vector:**
  - Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `key_valid` pulse.
  - Required: `busy` high 10 cycles, then `keys_done`=1.
  - `round_sel`=0 → 2b7e151628aed2a6abf7158809cf4f3c.
  - `round_sel`=1 → a0fafe1788542cb123a339392a6c7605.
  - `round_sel`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- **All-zero key:**
  - `rk[1]` = 62636363626363636263636362636363.
  - `rk[10]` = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Exercises the full rcon sequence including 1B and 36.
- **Reset mid-expansion:**
  - Stimulus: assert `reset`=0 for one edge at E5.
  - Required: `busy`=0, `keys_done`=0, `round_key`=0 for all `round_sel`, `key_ready`=1 next cycle.
  - A fresh FIPS key afterwards still expands correctly.
- **Handshake:**
  - Assert `key_valid` with the zero key during EXPAND of the FIPS key. It is ignored; the FIPS results are unchanged.
  - Offer the zero key in the first DONE cycle. It is accepted, and `keys_done` is 0 for 10 cycles, then 1 with the zero-key schedule.
- **Out-of-range index:** `round_sel`=11..15 in DONE → `round_key`=0, one cycle after the select.
- **Read latency:** change `round_sel` 0→10 at edge N. `round_key` shows `rk[0]` until edge N and `rk[10]` after edge N.
